// File: rtl/axi_rd_data_sink_if.sv
// AXI read-data channel bundle; the sink uses the master modport
// (payload in, rready out).
interface axi_rd_data_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [USER_WIDTH-1:0] ruser;

  modport master (input rvalid, rid, rdata, rresp, rlast, ruser, output rready);
  modport slave  (output rvalid, rid, rdata, rresp, rlast, ruser, input rready);
endinterface

// File: rtl/axi_rd_data_sink.sv
// R-channel consumer: checks each burst against its command and forwards
// the beats through a fall-through FIFO to a valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for a burst command, rready held low
// ACTIVE | accepting beats until the counted final beat
module axi_rd_data_sink #(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_MAX_WIDTH = 4,
  parameter int LEN_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ID_MAX_WIDTH-1:0] cmd_id,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  axi_rd_data_channel.master      r,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic [2:0]              err_status,
  input  logic                    err_clr,
  output logic                    busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state, state_nxt;
  logic                    cmd_ready_q;
  logic [ID_MAX_WIDTH-1:0] id_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    beat_cnt;
  logic [2:0]              err_q;
  logic [2:0]              err_new;

  logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;
  logic [DATA_WIDTH:0]     head;
  logic                    full, empty;

  logic                    rready_w;
  logic                    cmd_fire, beat_fire, beat_last, pop;
  logic                    unused_ruser;

  assign unused_ruser = ^r.ruser;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // rready depends only on registered state, never on out_ready
  assign rready_w  = (state == ACTIVE) && !full;
  assign r.rready  = rready_w;

  assign cmd_fire  = cmd_valid && cmd_ready_q;
  assign beat_fire = r.rvalid && rready_w;
  assign beat_last = (beat_cnt == len_q);
  assign pop       = !empty && out_ready;

  assign err_new = {beat_fire && (r.rlast != beat_last),
                    beat_fire && (r.rresp != 2'b00),
                    beat_fire && (r.rid != id_q)};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = ACTIVE;
      ACTIVE:  if (beat_fire && beat_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      err_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      cmd_ready_q <= (state_nxt == IDLE);
      if (cmd_fire) begin
        id_q     <= cmd_id;
        len_q    <= cmd_len;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      end
      // a fresh error in the clear cycle must survive the clear
      err_q <= (err_clr ? 3'b000 : err_q) | err_new;
      if (beat_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)       rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) mem[wr_ptr[AW-1:0]] <= {beat_last, r.rdata};
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : head[DATA_WIDTH-1:0];
  assign out_last   = !empty && head[DATA_WIDTH];
  assign cmd_ready  = cmd_ready_q;
  assign err_status = err_q;
  assign busy       = (state == ACTIVE) || !empty;
endmodule

// File: doc/axi_rd_data_sink.md
# axi_rd_data_sink

AXI read-data (R) channel consumer for the CNN datapath. Sits directly downstream of the R channel: it drives the `master` side of the `axi_rd_data_channel` interface and accepts beats one outstanding burst at a time. Each burst is described by a command from the read-address issuer, and the block checks the beats against it. Accepted data goes through an internal FIFO to a valid/ready stream feeding the compute array.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of rdata / out_data.
- `ID_MAX_WIDTH`, 4, width of rid / cmd_id.
- `LEN_WIDTH`, 8, width of cmd_len, which uses AXI encoding (beats − 1).
- `FIFO_DEPTH`, 8, data FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  burst command valid.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_id`  in  ID_MAX_WIDTH  expected rid for the burst.
- `cmd_len`  in  LEN_WIDTH  expected beats − 1.
- `r`  modport `axi_rd_data_channel.master`  —  rvalid/rid/rdata/rresp/rlast/ruser in, rready out; ruser ignored.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_WIDTH  stream payload.
- `out_last`  out  1  final beat of a burst.
- `err_status`  out  3  sticky errors: [0] rid mismatch, [1] rresp ≠ OKAY, [2] rlast mismatch.
- `err_clr`  in  1  clears err_status (1-cycle pulse).
- `busy`  out  1  burst in progress or FIFO non-empty.

## Operation
- **FSM states:** IDLE, ACTIVE.
- **IDLE:**
  - cmd_ready=1, rready=0.
  - On cmd_valid&cmd_ready: latch cmd_id and cmd_len, clear beat_cnt, go to ACTIVE.
- **ACTIVE:**
  - cmd_ready=0.
  - rready = !fifo_full. This is registered full state only; no combinational path from out_ready to rready.
- **Beat accept (rvalid&rready):**
  - Push {rdata, last = (beat_cnt == len_q)} into the FIFO.
  - beat_cnt increments.
- **Beat checks, on each accepted beat:**
  - rid ≠ id_q → set err[0].
  - rresp ≠ 2'b00 → set err[1].
  - rlast ≠ (beat_cnt == len_q) → set err[2].
- **End of burst:** the beat counter is authoritative. The burst ends on the counted final beat regardless of rlast, and the FSM returns to IDLE on the next edge. Any beats arriving after that are not accepted (rready=0 in IDLE).
- **Sticky errors:**
  - Error bits stay set until err_clr.
  - If err_clr and a new error occur in the same cycle, the new error wins (bit stays/gets set).
- **FIFO:**
  - First-word fall-through: out_valid = !empty, and out_data/out_last come from the head entry.
  - Pop on out_valid&out_ready.
  - Pointers are LOG2(FIFO_DEPTH)+1 bits and wrap naturally.
- **Simultaneous push and pop:**
  - Allowed when not full, with count unchanged.
  - When full, rready is already 0, so no push occurs even if a pop happens that cycle.
- **busy** = (state == ACTIVE) | !empty.
- **Reset mid-burst:**
  - FSM returns to IDLE, FIFO is emptied, counters and errors are cleared.
  - An in-flight burst is abandoned; the upstream side must also be reset.

## Timing
- **Reset values:**
  - cmd_ready=0. It is a register and becomes 1 on the first edge after rst_n goes high.
  - rready=0, out_valid=0, out_data=0, out_last=0, err_status=0, busy=0.
- **Command to first accept:** cmd handshake at edge N → rready=1 in cycle N+1 (if FIFO not full).
- **R beat to stream:** beat accepted at edge N → out_valid=1 in cycle N+1.
- **Error report:** err_status updates at the edge after the offending beat.
- **Burst turnaround:**
  - Final beat at edge N → IDLE and cmd_ready=1 in cycle N+1.
  - Next command accepted at edge N+1 at earliest, so there is one bubble cycle between bursts.
- **Throughput:** one beat per cycle when out_ready is held high.
- **Backpressure:** with out_ready=0, at most FIFO_DEPTH beats are accepted, then rready=0 until the first pop. rready rises the cycle after that pop.

## Test plan
1. **Single burst, no stall:**
   - Stimulus: cmd_id=3, cmd_len=3; four beats 0xA0..0xA3 with rid=3, rlast on beat 4; out_ready=1.
   - Required: four out beats in order, out_last on 0xA3 only, err_status=0, cmd_ready=1 one cycle after beat 4.
2. **Backpressure and FIFO full:**
   - Stimulus: cmd_len=15, rvalid held high, out_ready=0 for 20 cycles.
   - Required: exactly 8 beats accepted, then rready=0.
   - Release out_ready → all 16 beats delivered in order with no loss or duplication.
3. **rid / rresp errors:**
   - Stimulus: cmd_id=1, cmd_len=1; beat 0 rid=2, beat 1 rresp=2'b10.
   - Required: err_status=3'b011 after the burst; both beats still delivered.
   - Apply err_clr → err_status=0.
4. **rlast mismatch:**
   - Stimulus: cmd_len=3 with rlast on beat 2.
   - Required: err[2] set; burst still ends after 4 beats; out_last on beat 4.
   - Second case: cmd_len=1 with no rlast → err[2] set, FSM returns to IDLE.
5. **Back-to-back commands:**
   - Stimulus: two commands (len 0, then len 2) presented continuously.
   - Required: second cmd handshake one cycle after the first burst's beat; 4 beats total delivered; busy falls after the last pop.
6. **Reset mid-burst:**
   - Stimulus: rst_n=0 after 2 of 4 beats.
   - Required: next cycle out_valid=0, rready=0, err_status=0, busy=0; one cycle after release, cmd_ready=1.
